// File: rtl/task_12_serializer_sched.sv
// task_12_serializer_sched: round-robin scheduler sharing one serializer, with a tag stream aligned to its output words
module task_12_serializer_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int N_OUT = 3,
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ),
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic                                       i_en,
  input  logic [N_REQ-1:0][N_OUT-1:0][DATA_WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]                           i_req_valid,
  output logic [N_REQ-1:0]                           o_req_ready,
  output logic [N_OUT-1:0][DATA_WIDTH-1:0]           o_ser_data,
  output logic                                       o_ser_valid,
  output logic                                       o_tag_valid,
  output logic [ID_W-1:0]                            o_tag_id,
  output logic [IW-1:0]                              o_tag_idx,
  output logic                                       o_tag_last,
  output logic                                       o_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state, state_n;
  logic [IW-1:0] cnt;
  logic [ID_W-1:0] ptr, win, j, src, pend_id;
  logic found, gnt_ok, xfer, pend_v;
  logic [N_OUT-1:0][DATA_WIDTH-1:0] ser_q;
  // ptr holds the requester with top priority; scanning downward lets the nearest valid one win
  always_comb begin
    win = '0;
    j = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = ID_W'((int'(ptr) + i) % N_REQ);
      if (i_req_valid[j]) begin
        found = 1'b1;
        win = j;
      end
    end
  end
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_n;
  always_comb
    state_n = xfer ? ISSUE :
              (state == ISSUE && N_OUT > 1) ? HOLD :
              (state == HOLD && cnt != IW'(1)) ? HOLD : IDLE;
  always_comb begin
    gnt_ok = i_en && (state == IDLE || (state == HOLD && cnt == IW'(1)) || (state == ISSUE && N_OUT == 1));
    o_req_ready = (gnt_ok && found) ? N_REQ'(1) << win : '0;
    xfer = |o_req_ready;
    o_ser_valid = state == ISSUE;
    o_busy = xfer || state != IDLE || pend_v || o_tag_valid;
  end
  // pend stage gives the two-cycle issue-to-first-word latency of the serializer
  always_ff @(posedge i_clk)
    if (i_rst) begin
      ser_q <= '0;
      src <= '0;
      ptr <= '0;
      cnt <= '0;
      pend_v <= 1'b0;
      pend_id <= '0;
      o_tag_valid <= 1'b0;
      o_tag_id <= '0;
      o_tag_idx <= '0;
    end else begin
      if (xfer) begin
        ser_q <= i_req_data[win];
        src <= win;
        ptr <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
      cnt <= (state == ISSUE) ? IW'(N_OUT - 1) : (state == HOLD) ? cnt - 1'b1 : '0;
      pend_v <= state == ISSUE;
      pend_id <= src;
      if (pend_v) begin
        o_tag_valid <= 1'b1;
        o_tag_id <= pend_id;
        o_tag_idx <= '0;
      end else if (o_tag_valid && !o_tag_last) begin
        o_tag_idx <= o_tag_idx + 1'b1;
      end else begin
        o_tag_valid <= 1'b0;
        o_tag_id <= '0;
        o_tag_idx <= '0;
      end
    end
  assign o_tag_last = o_tag_valid && o_tag_idx == IW'(N_OUT - 1);
  assign o_ser_data = ser_q;
endmodule

// File: tb/tb_task_12_serializer_sched.sv
// tb_task_12_serializer_sched: scoreboard bench for the round-robin serializer scheduler
module tb_task_12_serializer_sched;
  localparam int DW = 32, NO = 3, NR = 4, IDW = 2, IW = 2;
  logic i_clk = 0, i_rst = 1, i_en = 0;
  logic [NR-1:0][NO-1:0][DW-1:0] i_req_data = '0;
  logic [NR-1:0] i_req_valid = '0, o_req_ready;
  logic [NO-1:0][DW-1:0] o_ser_data;
  logic o_ser_valid, o_tag_valid, o_tag_last, o_busy;
  logic [IDW-1:0] o_tag_id;
  logic [IW-1:0] o_tag_idx;
  int n_cmp = 0, n_err = 0, cyc = 0, last_iss = -100;
  int rem[NR] = '{default: 0};
  logic [NR-1:0] acc = '0;
  bit mon_on = 0;
  int gnt_log[$];
  typedef struct {int id; logic [NO-1:0][DW-1:0] d; int t;} iss_e;
  typedef struct {int id; int idx; int t;} tag_e;
  iss_e iss_q[$];
  tag_e tag_q[$];

  task_12_serializer_sched #(.DATA_WIDTH(DW), .N_OUT(NO), .N_REQ(NR)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_req_data(i_req_data),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .o_ser_data(o_ser_data),
    .o_ser_valid(o_ser_valid), .o_tag_valid(o_tag_valid), .o_tag_id(o_tag_id),
    .o_tag_idx(o_tag_idx), .o_tag_last(o_tag_last), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  initial forever begin
    @(posedge i_clk);
    cyc++;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [NO-1:0][DW-1:0] rand_vec();
    logic [NO-1:0][DW-1:0] v;
    for (int k = 0; k < NO; k++) v[k] = $urandom;
    return v;
  endfunction

  task automatic start(input int r, input int n);
    rem[r] = n;
    i_req_data[r] = rand_vec();
    i_req_valid[r] = 1'b1;
  endtask

  // requester side: advance to the next vector only after a transfer
  initial forever begin
    @(posedge i_clk);
    #1;
    for (int r = 0; r < NR; r++)
      if (acc[r]) begin
        rem[r]--;
        if (rem[r] > 0) i_req_data[r] = rand_vec();
        else i_req_valid[r] = 1'b0;
      end
  end

  // scoreboard: transfers push expected issues, issues push expected tags
  initial forever begin
    iss_e ie;
    tag_e te;
    @(negedge i_clk);
    acc = (i_rst || !mon_on) ? '0 : i_req_valid & o_req_ready;
    if (mon_on) begin
      n_cmp++;
      if ($countones(o_req_ready) > 1 || (o_req_ready & ~i_req_valid) != 0) begin
        n_err++;
        $display("FAIL ready_onehot: cyc=%0d ready=%b valid=%b", cyc, o_req_ready, i_req_valid);
      end
      for (int r = 0; r < NR; r++)
        if (acc[r]) begin
          ie.id = r;
          ie.d = i_req_data[r];
          ie.t = cyc;
          iss_q.push_back(ie);
          gnt_log.push_back(r);
        end
      if (o_ser_valid) begin
        n_cmp++;
        if (iss_q.size() == 0) begin
          n_err++;
          $display("FAIL ser_issue: cyc=%0d unexpected o_ser_valid", cyc);
        end else begin
          ie = iss_q.pop_front();
          if (o_ser_data !== ie.d || cyc != ie.t + 1 || cyc - last_iss < NO) begin
            n_err++;
            $display("FAIL ser_issue: cyc=%0d data=%h exp=%h xfer_cyc=%0d prev_issue=%0d", cyc, o_ser_data, ie.d, ie.t, last_iss);
          end
          last_iss = cyc;
          for (int k = 0; k < NO; k++) begin
            te.id = ie.id;
            te.idx = k;
            te.t = cyc + 2 + k;
            tag_q.push_back(te);
          end
        end
      end
      n_cmp++;
      if (o_tag_valid) begin
        if (tag_q.size() == 0) begin
          n_err++;
          $display("FAIL tag: cyc=%0d unexpected tag id=%0d idx=%0d", cyc, o_tag_id, o_tag_idx);
        end else begin
          te = tag_q.pop_front();
          if (o_tag_id !== te.id || o_tag_idx !== te.idx || o_tag_last !== (te.idx == NO - 1) || cyc != te.t) begin
            n_err++;
            $display("FAIL tag: cyc=%0d got id=%0d idx=%0d last=%b, exp id=%0d idx=%0d at cyc %0d", cyc, o_tag_id, o_tag_idx, o_tag_last, te.id, te.idx, te.t);
          end
        end
      end else if (o_tag_id !== 0 || o_tag_idx !== 0 || o_tag_last !== 0 || (tag_q.size() > 0 && tag_q[0].t <= cyc)) begin
        n_err++;
        $display("FAIL tag_idle: cyc=%0d id=%0d idx=%0d last=%b pending=%0d", cyc, o_tag_id, o_tag_idx, o_tag_last, tag_q.size());
      end
    end
    if (i_rst) begin
      iss_q.delete();
      tag_q.delete();
      last_iss = -100;
    end
  end

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge i_clk);
      done = !o_busy && i_req_valid == 0;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout: busy=%b valid=%b", nm, o_busy, i_req_valid);
    end
  endtask

  task automatic test_reset();
    i_rst = 1;
    i_en = 0;
    i_req_valid = '0;
    rem = '{default: 0};
    repeat (2) @(posedge i_clk);
    #2;
    i_rst = 0;
    i_en = 1;
    mon_on = 1;
    @(negedge i_clk);
    n_cmp += 3;
    if (o_ser_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", o_ser_data);
    end
    if ({o_req_ready, o_ser_valid, o_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: ready=%b ser_valid=%b busy=%b want 0", o_req_ready, o_ser_valid, o_busy);
    end
    if ({o_tag_valid, o_tag_id, o_tag_idx, o_tag_last} !== '0) begin
      n_err++;
      $display("FAIL reset_tag: v=%b id=%0d idx=%0d last=%b want 0", o_tag_valid, o_tag_id, o_tag_idx, o_tag_last);
    end
  endtask

  task automatic test_single();
    logic [NO-1:0][DW-1:0] v;
    v[0] = 32'hAAAA_0001;
    v[1] = 32'hBBBB_0002;
    v[2] = 32'hCCCC_0003;
    @(posedge i_clk);
    #2;
    i_req_data[2] = v;
    i_req_valid[2] = 1'b1;
    rem[2] = 1;
    @(negedge i_clk);
    n_cmp++;
    if (o_req_ready !== 4'b0100 || o_busy !== 1) begin
      n_err++;
      $display("FAIL single_grant: ready=%b busy=%b want 0100/1", o_req_ready, o_busy);
    end
    @(negedge i_clk);
    n_cmp++;
    if (o_ser_valid !== 1 || o_ser_data !== v || o_busy !== 1) begin
      n_err++;
      $display("FAIL single_issue: valid=%b data=%h busy=%b want 1/%h/1", o_ser_valid, o_ser_data, o_busy, v);
    end
    @(negedge i_clk);
    n_cmp++;
    if (o_tag_valid !== 0 || o_ser_valid !== 0 || o_busy !== 1) begin
      n_err++;
      $display("FAIL single_gap: tag_valid=%b ser_valid=%b busy=%b want 0/0/1", o_tag_valid, o_ser_valid, o_busy);
    end
    for (int k = 0; k < NO; k++) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_tag_valid !== 1 || o_tag_id !== 2 || o_tag_idx !== k || o_tag_last !== (k == NO - 1) || o_busy !== 1) begin
        n_err++;
        $display("FAIL single_tag%0d: v=%b id=%0d idx=%0d last=%b busy=%b want 1/2/%0d/%0d/1", k, o_tag_valid, o_tag_id, o_tag_idx, o_tag_last, o_busy, k, k == NO - 1);
      end
    end
    @(negedge i_clk);
    n_cmp++;
    if (o_busy !== 0 || o_tag_valid !== 0) begin
      n_err++;
      $display("FAIL single_done: busy=%b tag_valid=%b want 0/0", o_busy, o_tag_valid);
    end
  endtask

  task automatic test_continuous();
    int iq[$], tq[$], tc[$];
    int order[5] = '{0, 1, 2, 3, 0};
    gnt_log.delete();
    @(posedge i_clk);
    #2;
    for (int r = 0; r < NR; r++) start(r, 3);
    for (int k = 0; k < 400; k++) begin
      @(negedge i_clk);
      if (o_ser_valid) iq.push_back(cyc);
      if (o_tag_valid) begin
        tq.push_back(o_tag_id);
        tc.push_back(cyc);
      end
      if (rem.sum() == 0 && !o_busy) break;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (gnt_log.size() <= i || gnt_log[i] != order[i]) begin
        n_err++;
        $display("FAIL cont_order%0d: got %0d want %0d", i, gnt_log.size() > i ? gnt_log[i] : -1, order[i]);
      end
    end
    for (int i = 1; i < iq.size(); i++) begin
      n_cmp++;
      if (iq[i] - iq[i-1] != NO) begin
        n_err++;
        $display("FAIL cont_spacing: issue gap %0d want %0d", iq[i] - iq[i-1], NO);
      end
    end
    n_cmp++;
    if (tq.size() != 36 || tc[tc.size()-1] - tc[0] != 35) begin
      n_err++;
      $display("FAIL cont_stream: tags=%0d span=%0d want 36/35", tq.size(), tc.size() > 0 ? tc[tc.size()-1] - tc[0] : -1);
    end
    for (int i = 0; i < tq.size(); i++) begin
      n_cmp++;
      if (tq[i] != (i / 3) % 4) begin
        n_err++;
        $display("FAIL cont_tag_id%0d: got %0d want %0d", i, tq[i], (i / 3) % 4);
      end
    end
  endtask

  task automatic test_rr_fairness();
    int exp[3] = '{1, 3, 1};
    wait_idle("rr_pre");
    gnt_log.delete();
    @(posedge i_clk);
    #2;
    start(1, 1);
    wait_idle("rr_first");
    @(posedge i_clk);
    #2;
    start(1, 1);
    start(3, 1);
    @(negedge i_clk);
    n_cmp++;
    if (o_req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL rr_ready: got %b want 1000", o_req_ready);
    end
    wait_idle("rr");
    n_cmp++;
    if (gnt_log.size() != 3) begin
      n_err++;
      $display("FAIL rr_count: got %0d grants want 3", gnt_log.size());
    end else
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (gnt_log[i] != exp[i]) begin
          n_err++;
          $display("FAIL rr_order%0d: got %0d want %0d", i, gnt_log[i], exp[i]);
        end
      end
  endtask

  task automatic test_en_drop();
    int ntag = 0, nrdy = 0;
    int exp[8] = '{2, 3, 0, 1, 2, 3, 0, 1};
    gnt_log.delete();
    @(posedge i_clk);
    #2;
    for (int r = 0; r < NR; r++) start(r, 2);
    for (int k = 0; k < 20 && gnt_log.size() == 0; k++) @(negedge i_clk);
    @(posedge i_clk);
    #2;
    i_en = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      if (o_tag_valid) ntag++;
      if (o_req_ready != 0) nrdy++;
    end
    n_cmp++;
    if (ntag != 3 || nrdy != 0 || o_busy !== 0 || gnt_log.size() != 1) begin
      n_err++;
      $display("FAIL en_hold: tags=%0d readies=%0d busy=%b grants=%0d want 3/0/0/1", ntag, nrdy, o_busy, gnt_log.size());
    end
    @(posedge i_clk);
    #2;
    i_en = 1;
    wait_idle("en_resume");
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (gnt_log.size() <= i || gnt_log[i] != exp[i]) begin
        n_err++;
        $display("FAIL en_order%0d: got %0d want %0d", i, gnt_log.size() > i ? gnt_log[i] : -1, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int nact = 0;
    gnt_log.delete();
    @(posedge i_clk);
    #2;
    for (int r = 0; r < NR; r++) start(r, 2);
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge i_clk);
      seen = o_tag_valid && o_tag_idx == 0;
    end
    @(posedge i_clk);
    #2;
    i_rst = 1;
    i_req_valid = '0;
    rem = '{default: 0};
    @(negedge i_clk);
    n_cmp++;
    if (o_tag_idx !== 1) begin
      n_err++;
      $display("FAIL rmid_setup: tag idx=%0d want 1", o_tag_idx);
    end
    @(posedge i_clk);
    #2;
    i_rst = 0;
    @(negedge i_clk);
    n_cmp++;
    if ({o_req_ready, o_ser_valid, o_busy, o_tag_valid, o_tag_id, o_tag_idx, o_tag_last} !== '0) begin
      n_err++;
      $display("FAIL rmid_clear: ready=%b sv=%b busy=%b tv=%b id=%0d idx=%0d last=%b want 0", o_req_ready, o_ser_valid, o_busy, o_tag_valid, o_tag_id, o_tag_idx, o_tag_last);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (o_ser_valid || o_tag_valid || o_busy) nact++;
    end
    n_cmp++;
    if (nact != 0) begin
      n_err++;
      $display("FAIL rmid_quiet: %0d active cycles want 0", nact);
    end
    gnt_log.delete();
    @(posedge i_clk);
    #2;
    for (int r = 0; r < NR; r++) start(r, 1);
    wait_idle("rmid_ptr");
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (gnt_log.size() <= i || gnt_log[i] != i) begin
        n_err++;
        $display("FAIL rmid_order%0d: got %0d want %0d", i, gnt_log.size() > i ? gnt_log[i] : -1, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp[4] = '{0, 1, 0, 0};
    int waited = 0;
    gnt_log.delete();
    @(posedge i_clk);
    #2;
    start(0, 3);
    start(1, 1);
    for (int k = 0; k < 100 && (o_busy || i_req_valid != 0); k++) begin
      @(negedge i_clk);
      if (i_req_valid[1] && o_req_ready[0]) waited++;
    end
    n_cmp++;
    if (waited != 1 || i_req_valid !== 0) begin
      n_err++;
      $display("FAIL b2b_wait: r1 blocked %0d times, valid=%b want 1/0000", waited, i_req_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (gnt_log.size() <= i || gnt_log[i] != exp[i]) begin
        n_err++;
        $display("FAIL b2b_order%0d: got %0d want %0d", i, gnt_log.size() > i ? gnt_log[i] : -1, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset();
    test_continuous();
    test_rr_fairness();
    test_en_drop();
    test_reset_mid();
    test_back_to_back();
    wait_idle("final");
    n_cmp++;
    if (iss_q.size() != 0 || tag_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d issues and %0d tags never seen", iss_q.size(), tag_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
